// File: rtl/rate_enable_gen.sv
// -----------------------------------------------------------------------------
// rate_enable_gen
//
// Programmable enable-pulse generator for a downstream 8-bit T-flip-flop
// counter. A two-state FSM (IDLE/RUN) free-runs a down-counter that issues a
// one-cycle enable every DIV(rate_sel) clocks while run is high. With
// rate_sel = 00 the enable is held high on every RUN cycle.
//
// Optional feature (macro RATE_STEP_EN): a push button on step_n is
// synchronised and its falling edge produces a single enable pulse while the
// FSM is in IDLE. Without the macro, step_n is ignored and IDLE never pulses.
//
// Parameters:
//   DIV_1HZ, DIV_2HZ, DIV_4HZ - clock cycles per pulse for rate_sel 01/10/11
//   CNT_W                     - divider width, must hold every DIV_* - 1
//
// Ports:
//   clk      in   rising-edge clock
//   clr      in   asynchronous active-low reset
//   run      in   level, 1 = free-run pulse generation
//   rate_sel in   [1:0] 00 every cycle, 01 DIV_1HZ, 10 DIV_2HZ, 11 DIV_4HZ
//   step_n   in   raw active-low single-step button (RATE_STEP_EN only)
//   en_pulse out  registered one-cycle enable
//   running  out  registered, 1 while the FSM is in RUN
//   div_cnt  out  [CNT_W-1:0] current divider count
// -----------------------------------------------------------------------------
module rate_enable_gen #(
  parameter int unsigned DIV_1HZ = 50000000,
  parameter int unsigned DIV_2HZ = 25000000,
  parameter int unsigned DIV_4HZ = 12500000,
  parameter int unsigned CNT_W   = 28
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [1:0]       rate_sel,
  input  logic             step_n,
  output logic             en_pulse,
  output logic             running,
  output logic [CNT_W-1:0] div_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  sel_q;       // registered copy of rate_sel, detects rate changes
  logic        step_edge;   // one-cycle falling-edge strobe from step_n
  logic [CNT_W-1:0] reload;

  // Reload value DIV(sel) - 1; sel = 00 means divide-by-one.
  function automatic logic [CNT_W-1:0] reload_of(input logic [1:0] sel);
    case (sel)
      2'b01:   reload_of = CNT_W'(DIV_1HZ - 1);
      2'b10:   reload_of = CNT_W'(DIV_2HZ - 1);
      2'b11:   reload_of = CNT_W'(DIV_4HZ - 1);
      default: reload_of = '0;
    endcase
  endfunction

  assign reload = reload_of(rate_sel);

`ifdef RATE_STEP_EN
  logic step_s1, step_s2, step_s3;

  // Two-flop synchroniser plus one history flop. Flops rest at 1 (button
  // released) so reset can never fabricate an edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      step_s1 <= 1'b1;
      step_s2 <= 1'b1;
      step_s3 <= 1'b1;
    end else begin
      step_s1 <= step_n;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  assign step_edge = step_s3 & ~step_s2;
`else
  logic unused_step_n;
  assign unused_step_n = step_n;
  assign step_edge     = 1'b0;
`endif

  // NOTE: every register here is assigned with <= so all flops sample the
  // pre-edge values of each other; a blocking = would let later statements
  // see already-updated state and silently change the cycle behaviour.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      // NOTE: the async reset clears every flop of the block, including the
      // rate_sel copy, so the first edge after release starts from a known
      // IDLE state regardless of clk activity during reset.
      state    <= IDLE;
      en_pulse <= 1'b0;
      running  <= 1'b0;
      div_cnt  <= '0;
      sel_q    <= 2'b00;
    end else begin
      sel_q   <= rate_sel;
      // The next state is RUN exactly when run is high, in either state.
      running <= run;

      case (state)
        IDLE: begin
          div_cnt  <= reload;
          en_pulse <= step_edge;
          if (run) state <= RUN;
        end

        RUN: begin
          if (!run) begin
            // Deassert wins over a terminal count: no pulse on this edge.
            state    <= IDLE;
            div_cnt  <= reload;
            en_pulse <= 1'b0;
          end else if (rate_sel != sel_q) begin
            // Rate change restarts the period from the new divider.
            div_cnt  <= reload;
            en_pulse <= 1'b0;
          end else if (div_cnt == '0) begin
            div_cnt  <= reload;
            en_pulse <= 1'b1;
          end else begin
            div_cnt  <= div_cnt - 1'b1;
            en_pulse <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rate_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_rate_enable_gen
//
// Scoreboard bench for rate_enable_gen (DIV_1HZ=4, DIV_2HZ=3, DIV_4HZ=2).
// The stimulus process drives inputs on the falling edge, advances a
// behavioural model that tracks elapsed RUN cycles since the last (re)start,
// and pushes the expected post-edge outputs into a queue. The monitor pops one
// entry after every rising edge and compares. Directed scenarios are followed
// by a randomised phase. Define RATE_STEP_EN for both RTL and bench to cover
// the single-step feature.
// -----------------------------------------------------------------------------
module tb_rate_enable_gen;

  localparam int CNT_W = 8;
  localparam int D1    = 4;
  localparam int D2    = 3;
  localparam int D4    = 2;
`ifdef RATE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             run = 1'b0;
  logic [1:0]       rate_sel = 2'b00;
  logic             step_n = 1'b1;
  logic             en_pulse;
  logic             running;
  logic [CNT_W-1:0] div_cnt;

  rate_enable_gen #(
    .DIV_1HZ(D1), .DIV_2HZ(D2), .DIV_4HZ(D4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clr(clr), .run(run), .rate_sel(rate_sel), .step_n(step_n),
    .en_pulse(en_pulse), .running(running), .div_cnt(div_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     en;
    logic     run;
    int       cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_item;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   m_run;      // FSM is in RUN
  int   m_t;        // RUN edges elapsed since the period last (re)started
  logic [1:0] m_prev_sel;
  logic step_hist[3]; // step_n samples from the last three edges, newest first

  function automatic int div_of(input logic [1:0] sel);
    case (sel)
      2'b01:   return D1;
      2'b10:   return D2;
      2'b11:   return D4;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_run      = 1'b0;
    m_t        = 0;
    m_prev_sel = 2'b00;
    for (int i = 0; i < 3; i++) step_hist[i] = 1'b1;
  endtask

  // Predict the outputs after the coming rising edge for the current inputs.
  task automatic model_edge(output exp_t e);
    int  d;
    bit  fell;
    d    = div_of(rate_sel);
    // Edge seen when the sample two edges back is low and three back is high.
    fell = (step_hist[2] == 1'b1) && (step_hist[1] == 1'b0);
    if (!m_run) begin
      e.en  = STEP_EN && fell;
      e.cnt = d - 1;
      m_t   = 0;
      m_run = run;
    end else if (!run) begin
      e.en  = 1'b0;
      e.cnt = d - 1;
      m_run = 1'b0;
    end else if (rate_sel != m_prev_sel) begin
      m_t   = 0;
      e.en  = 1'b0;
      e.cnt = d - 1;
    end else begin
      m_t++;
      e.en  = (m_t % d) == 0;
      e.cnt = d - 1 - (m_t % d);
    end
    e.run      = m_run;
    m_prev_sel = rate_sel;
    step_hist[2] = step_hist[1];
    step_hist[1] = step_hist[0];
    step_hist[0] = step_n;
  endtask

  // Drive one cycle of inputs (caller is at a falling edge), queue the
  // expectation for the next rising edge, then move to the next falling edge.
  task automatic cycle(input logic r, input logic [1:0] s, input logic st);
    exp_t e;
    run      = r;
    rate_sel = s;
    step_n   = st;
    model_edge(e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic cycles(input int n, input logic r, input logic [1:0] s,
                        input logic st);
    for (int i = 0; i < n; i++) cycle(r, s, st);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (clr && exp_q.size() > 0) begin
      mon_item = exp_q.pop_front();
      check("en_pulse", int'(en_pulse), int'(mon_item.en));
      check("running",  int'(running),  int'(mon_item.run));
      check("div_cnt",  int'(div_cnt),  mon_item.cnt);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       r_r;
    logic [1:0] r_s;
    logic       r_st;

    model_reset();
    #2;
    check("reset_en_pulse", int'(en_pulse), 0);
    check("reset_running",  int'(running),  0);
    check("reset_div_cnt",  int'(div_cnt),  0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;

    // Free run at DIV_1HZ: pulses on edges 4, 8, 12 after entry.
    cycles(14, 1'b1, 2'b01, 1'b1);
    cycles(2,  1'b0, 2'b01, 1'b1);
    // Every-cycle mode, then stop.
    cycles(6,  1'b1, 2'b00, 1'b1);
    cycles(2,  1'b0, 2'b00, 1'b1);
    // Rate change with div_cnt=1: reload to 1, pulses every 2 cycles.
    cycles(3,  1'b1, 2'b01, 1'b1);
    cycles(7,  1'b1, 2'b11, 1'b1);
    cycles(2,  1'b0, 2'b11, 1'b1);
    // run falls on the terminal-count edge: no pulse, reload to 3.
    cycles(4,  1'b1, 2'b01, 1'b1);
    cycles(2,  1'b0, 2'b01, 1'b1);
    // Step button in IDLE, then in RUN.
    cycles(10, 1'b0, 2'b01, 1'b0);
    cycles(5,  1'b0, 2'b01, 1'b1);
    cycles(3,  1'b1, 2'b10, 1'b1);
    cycles(10, 1'b1, 2'b10, 1'b0);
    cycles(5,  1'b1, 2'b10, 1'b1);

    // Async clear mid-RUN while en_pulse is high.
    cycles(4, 1'b1, 2'b00, 1'b1);
    @(posedge clk);
    #3;
    check("pre_clr_en_pulse", int'(en_pulse), 1);
    clr = 1'b0;
    #1;
    check("clr_en_pulse", int'(en_pulse), 0);
    check("clr_running",  int'(running),  0);
    check("clr_div_cnt",  int'(div_cnt),  0);
    @(posedge clk);
    #1;
    check("clr_hold_running", int'(running), 0);
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    cycles(2,  1'b0, 2'b01, 1'b1);
    cycles(10, 1'b1, 2'b01, 1'b1);
    cycles(2,  1'b0, 2'b01, 1'b1);

    // Randomised phase with sticky inputs.
    r_r = 1'b0; r_s = 2'b00; r_st = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) r_r  = ~r_r;
      if ($urandom_range(19) == 0) r_s  = 2'($urandom_range(3));
      if ($urandom_range(7)  == 0) r_st = ~r_st;
      cycle(r_r, r_s, r_st);
    end
    cycles(3, 1'b0, 2'b00, 1'b1);

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
